// File: rtl/bf16_mul_stage.sv
`default_nettype none
// ============================================================================
//  Module   : bf16_mul_stage
//  Purpose  : Sequential BF16 multiplier (iterative shift-add mantissa product),
//             valid/ready on both sides, flush-to-zero and truncating rounding.
//  Revision : 1.0  initial release
// ============================================================================
module bf16_mul_stage #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] num1,
    input  logic [15:0] num2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        zero,
    output logic        underflow,
    output logic        overflow,
    output logic        qNaN,
    output logic        sNaN,
    output logic        positive_inf,
    output logic        negative_inf
);

    localparam int         c_ITERS  = 8 / BITS_PER_CYCLE;
    localparam logic [3:0] c_LAST   = 4'(c_ITERS - 1);
    // Bit positions inside the packed flag vector
    localparam int c_F_ZERO = 6;
    localparam int c_F_UNF  = 5;
    localparam int c_F_OVF  = 4;
    localparam int c_F_QNAN = 3;
    localparam int c_F_SNAN = 2;
    localparam int c_F_PINF = 1;
    localparam int c_F_NINF = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sign;
    logic [7:0]  r_e1;
    logic [7:0]  r_e2;
    logic [15:0] r_mcand;
    logic [7:0]  r_mplier;
    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic [15:0] r_result;
    logic [6:0]  r_flags;

    logic        w_accept;
    logic        w_sign;
    logic        w_a_zero, w_a_inf, w_a_nan, w_a_snan;
    logic        w_b_zero, w_b_inf, w_b_nan, w_b_snan;
    logic        w_special;
    logic [15:0] w_spec_result;
    logic [6:0]  w_spec_flags;
    logic [15:0] w_pp_sum;
    logic signed [9:0] w_exp_base;
    logic signed [9:0] w_exp;
    logic [6:0]  w_mant;
    logic [15:0] w_norm_result;
    logic [6:0]  w_norm_flags;
    logic        w_unused_bits;

    assign in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_sign   = num1[15] ^ num2[15];

    // Operand classification; exponent 0 flushes any mantissa to zero
    assign w_a_zero = (num1[14:7] == 8'h00);
    assign w_a_inf  = (num1[14:7] == 8'hFF) & (num1[6:0] == 7'h00);
    assign w_a_nan  = (num1[14:7] == 8'hFF) & (num1[6:0] != 7'h00);
    assign w_a_snan = w_a_nan & ~num1[6];
    assign w_b_zero = (num2[14:7] == 8'h00);
    assign w_b_inf  = (num2[14:7] == 8'hFF) & (num2[6:0] == 7'h00);
    assign w_b_nan  = (num2[14:7] == 8'hFF) & (num2[6:0] != 7'h00);
    assign w_b_snan = w_b_nan & ~num2[6];

    assign w_special = w_a_zero | w_a_inf | w_a_nan | w_b_zero | w_b_inf | w_b_nan;

    always_comb begin
        w_spec_result = 16'h0000;
        w_spec_flags  = 7'b0;
        if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
            w_spec_result          = 16'h7FC0;
            w_spec_flags[c_F_QNAN] = 1'b1;
            w_spec_flags[c_F_SNAN] = w_a_snan | w_b_snan;
        end else if (w_a_inf | w_b_inf) begin
            w_spec_result          = {w_sign, 8'hFF, 7'h00};
            w_spec_flags[c_F_PINF] = ~w_sign;
            w_spec_flags[c_F_NINF] = w_sign;
        end else if (w_a_zero | w_b_zero) begin
            w_spec_result          = {w_sign, 15'h0000};
            w_spec_flags[c_F_ZERO] = 1'b1;
        end
    end

    // Low multiplier bits select shifted copies of the multiplicand this cycle
    always_comb begin
        w_pp_sum = 16'h0000;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_mplier[k]) begin
                w_pp_sum = w_pp_sum + (r_mcand << k);
            end
        end
    end

    assign w_exp_base = $signed({2'b00, r_e1}) + $signed({2'b00, r_e2}) - 10'sd127;
    assign w_exp      = r_acc[15] ? (w_exp_base + 10'sd1) : w_exp_base;
    assign w_mant     = r_acc[15] ? r_acc[14:8] : r_acc[13:7];
    assign w_unused_bits = ^r_acc[6:0];

    always_comb begin
        w_norm_result = {r_sign, w_exp[7:0], w_mant};
        w_norm_flags  = 7'b0;
        if (w_exp >= 10'sd255) begin
            w_norm_result          = {r_sign, 8'hFF, 7'h00};
            w_norm_flags[c_F_OVF]  = 1'b1;
            w_norm_flags[c_F_PINF] = ~r_sign;
            w_norm_flags[c_F_NINF] = r_sign;
        end else if (w_exp <= 10'sd0) begin
            w_norm_result          = {r_sign, 15'h0000};
            w_norm_flags[c_F_UNF]  = 1'b1;
            w_norm_flags[c_F_ZERO] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_NORM;
                end
            end
            S_NORM: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end else if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign   <= 1'b0;
            r_e1     <= 8'h00;
            r_e2     <= 8'h00;
            r_mcand  <= 16'h0000;
            r_mplier <= 8'h00;
            r_acc    <= 16'h0000;
            r_cnt    <= 4'h0;
            r_result <= 16'h0000;
            r_flags  <= 7'b0;
        end else if (w_accept) begin
            r_sign   <= w_sign;
            r_e1     <= num1[14:7];
            r_e2     <= num2[14:7];
            r_mcand  <= {8'h00, 1'b1, num1[6:0]};
            r_mplier <= {1'b1, num2[6:0]};
            r_acc    <= 16'h0000;
            r_cnt    <= 4'h0;
            if (w_special) begin
                r_result <= w_spec_result;
                r_flags  <= w_spec_flags;
            end
        end else if (r_state == S_CALC) begin
            r_acc    <= r_acc + w_pp_sum;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_cnt    <= r_cnt + 4'h1;
        end else if (r_state == S_NORM) begin
            r_result <= w_norm_result;
            r_flags  <= w_norm_flags;
        end
    end

    assign out_valid    = (r_state == S_DONE);
    assign result       = r_result;
    assign zero         = r_flags[c_F_ZERO];
    assign underflow    = r_flags[c_F_UNF];
    assign overflow     = r_flags[c_F_OVF];
    assign qNaN         = r_flags[c_F_QNAN];
    assign sNaN         = r_flags[c_F_SNAN];
    assign positive_inf = r_flags[c_F_PINF];
    assign negative_inf = r_flags[c_F_NINF];

endmodule
`default_nettype wire

// File: doc/bf16_mul_stage.md
Name: bf16_mul_stage

Overview:
Sequential BF16 multiplier forming the multiply half of the BF16 FMA datapath. Its registered product and flags feed the BF16 adder's num1 input directly.
Multiplies two BF16 operands with an iterative shift-add mantissa datapath. Uses a valid/ready handshake on input and output, and produces the same flag set the adder uses.
Denormals are flushed to zero and rounding is by truncation, matching the downstream adder.

Parameters:
BITS_PER_CYCLE, 1, multiplier bits consumed per CALC cycle; legal values 1, 2, 4, 8; CALC lasts 8/BITS_PER_CYCLE cycles.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
num1  in  16  BF16 operand A {sign, exp[7:0], mant[6:0]}
num2  in  16  BF16 operand B
in_valid  in  1  operands valid
in_ready  out  1  stage can accept operands
result  out  16  BF16 product, registered
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts result
zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf  out  1 each  registered status flags qualifying result

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; result=16'h0000; all flags=0; out_valid=0.
  - Applies mid-operation too: any in-flight product is discarded and not emitted.
- FSM states are IDLE, CALC, NORM, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
  - This allows back-to-back accept on the same edge as output retire.
- Accept occurs at an edge with in_valid & in_ready. At accept:
  - Capture signs, exponents and mantissas {1,mant}.
  - s = sign1 ^ sign2.
  - Classify each operand: ZERO (exp==0, any mant), INF (exp==FF, mant==0), NAN (exp==FF, mant!=0; quiet if mant[6]=1, else signalling), otherwise NORMAL.
- Special cases resolve at the accept edge; state goes to DONE (latency 1). Priority, highest first:
  1. Any NAN input, or INF×ZERO: result=16'h7FC0, qNaN=1; sNaN=1 additionally if any input was signalling.
  2. Any INF input: result={s,8'hFF,7'h0}; positive_inf=~s, negative_inf=s.
  3. Any ZERO input: result={s,15'h0}; zero=1.
- Both inputs NORMAL:
  - At accept: state goes to CALC; acc=0; iteration counter=0.
  - Each CALC edge adds BITS_PER_CYCLE partial products of the 8×8 mantissa product into a 16-bit accumulator.
  - After the last CALC edge, state goes to NORM.
- NORM edge:
  - E = e1 + e2 - 127, computed 10-bit signed.
  - If P[15]: E = E+1 and M = P[14:8]; else M = P[13:7]. Lower bits are truncated.
  - Overflow (E >= 255): result={s,8'hFF,7'h0}; overflow=1; positive_inf or negative_inf set per s.
  - Underflow (E <= 0): result={s,15'h0}; underflow=1, zero=1.
  - Otherwise: result={s,E[7:0],M}.
  - State goes to DONE.
- Latency, accept edge to out_valid: 8/BITS_PER_CYCLE + 1 cycles for NORMAL operands (9 cycles at default); 1 cycle for special cases.
- DONE:
  - out_valid=1; result and flags held stable until out_ready=1 at an edge.
  - On retire: go to IDLE, or directly to CALC/DONE if a new accept occurs on the same edge.
  - Flags are cleared and rewritten whenever a new result is loaded; no flag is sticky across results.
- Outside DONE: out_valid=0, and result/flags hold their last values (don't-care to the consumer).
- Input changes during CALC/NORM are ignored; operands are held internally.

Test Plan:
- num1=3F80 (1.0), num2=4000 (2.0), BITS_PER_CYCLE=1 -> result=4000, all flags 0; out_valid asserted exactly 9 cycles after the accept edge.
- 3FC0 × 3FC0 (1.5×1.5) -> result=4010 (2.25), flags 0. Repeat with BITS_PER_CYCLE=8 -> same result, latency 2.
- 7F00 × 4000 -> result=7F80, overflow=1, positive_inf=1.
- 7F00 × C000 -> result=FF80, overflow=1, negative_inf=1.
- 0080 × 0080 -> result=0000, underflow=1, zero=1.
- 7F80 × 0000 -> result=7FC0, qNaN=1, latency 1.
- 7F81 × 3F80 -> result=7FC0, qNaN=1, sNaN=1.
- 8000 × 4000 -> result=8000, zero=1.
- Hold out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0. Raise out_ready with in_valid=1 -> retire and new accept on the same edge.
- Assert rst=1 for one edge mid-CALC -> next cycle out_valid=0, result=0000, all flags 0, in_ready=1; the aborted product is never emitted.
